// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall detection.
// Feeds srcA/srcB and the ALU control code straight into the EX-stage ALU.

module ex_fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic [XLEN-1:0] reg_i,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [RA_W-1:0] rd_m,
  input  logic            reg_write_m,
  input  logic [XLEN-1:0] result_w,
  input  logic [RA_W-1:0] rd_w,
  input  logic            reg_write_w,
  output logic [XLEN-1:0] fwd_o
);
  logic hit_m, hit_w;

  // x0 is hardwired zero, so a write to it must never be forwarded.
  assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_i);
  assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_i);

  always_comb begin
    fwd_o = reg_i;
    if (hit_m)      fwd_o = alu_result_m;
    else if (hit_w) fwd_o = result_w;
  end
endmodule

module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  input  logic [RA_W-1:0] rd_d,
  input  logic [2:0]      alu_control_d,
  input  logic            alu_src_d,
  input  logic            reg_write_d,
  input  logic            mem_read_d,
  input  logic            mem_write_d,
  input  logic            flush_e,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [RA_W-1:0] rd_m,
  input  logic            reg_write_m,
  input  logic [XLEN-1:0] result_w,
  input  logic [RA_W-1:0] rd_w,
  input  logic            reg_write_w,
  output logic            stall_d,
  output logic [XLEN-1:0] srcA,
  output logic [XLEN-1:0] srcB,
  output logic [2:0]      alu_control_e,
  output logic [XLEN-1:0] write_data_e,
  output logic [XLEN-1:0] pc_e,
  output logic [RA_W-1:0] rd_e,
  output logic            valid_e,
  output logic            reg_write_e,
  output logic            mem_read_e,
  output logic            mem_write_e
);
  localparam int NOPS = 2;

  logic            valid_q, alu_src_q, reg_write_q, mem_read_q, mem_write_q;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic [2:0]      alu_control_q;

  logic [NOPS-1:0][RA_W-1:0] rs_e;
  logic [NOPS-1:0][XLEN-1:0] rdat_e;
  logic [NOPS-1:0][XLEN-1:0] fwd_e;

  // Load in EX whose destination is read by decode: one bubble, then WB forward covers it.
  assign stall_d = valid_q && mem_read_q && (rd_q != '0) && valid_d &&
                   ((rd_q == rs1_d) || (rd_q == rs2_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_control_q <= '0;
      alu_src_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else if (flush_e || stall_d) begin
      // Bubble: kill side effects only, data fields keep their old values.
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      alu_control_q <= alu_control_d;
      alu_src_q     <= alu_src_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  assign rs_e   = {rs2_q, rs1_q};
  assign rdat_e = {rd2_q, rd1_q};

  for (genvar g = 0; g < NOPS; g++) begin : g_fwd
    ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
      .rs_i         (rs_e[g]),
      .reg_i        (rdat_e[g]),
      .alu_result_m (alu_result_m),
      .rd_m         (rd_m),
      .reg_write_m  (reg_write_m),
      .result_w     (result_w),
      .rd_w         (rd_w),
      .reg_write_w  (reg_write_w),
      .fwd_o        (fwd_e[g])
    );
  end

  assign srcA          = fwd_e[0];
  assign srcB          = alu_src_q ? imm_q : fwd_e[1];
  assign write_data_e  = fwd_e[1];
  assign alu_control_e = alu_control_q;
  assign pc_e          = pc_q;
  assign rd_e          = rd_q;
  assign valid_e       = valid_q;
  assign reg_write_e   = reg_write_q;
  assign mem_read_e    = mem_read_q;
  assign mem_write_e   = mem_write_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed plus random checks of ex_operand_stage against a pipeline-level reference model.
module tb_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_d;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d, pc_d;
  logic [RA_W-1:0] rs1_d, rs2_d, rd_d;
  logic [2:0]      alu_control_d;
  logic            alu_src_d, reg_write_d, mem_read_d, mem_write_d, flush_e;
  logic [XLEN-1:0] alu_result_m, result_w;
  logic [RA_W-1:0] rd_m, rd_w;
  logic            reg_write_m, reg_write_w;
  logic            stall_d;
  logic [XLEN-1:0] srcA, srcB, write_data_e, pc_e;
  logic [2:0]      alu_control_e;
  logic [RA_W-1:0] rd_e;
  logic            valid_e, reg_write_e, mem_read_e, mem_write_e;

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the instruction sitting in EX.
  typedef struct {
    logic            valid, src, rw, mr, mw;
    logic [XLEN-1:0] rd1, rd2, imm, pc;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [2:0]      ctl;
  } ex_t;
  ex_t m;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_d(imm_d), .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .alu_control_d(alu_control_d), .alu_src_d(alu_src_d), .reg_write_d(reg_write_d),
    .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .flush_e(flush_e),
    .alu_result_m(alu_result_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .result_w(result_w), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .stall_d(stall_d), .srcA(srcA), .srcB(srcB), .alu_control_e(alu_control_e),
    .write_data_e(write_data_e), .pc_e(pc_e), .rd_e(rd_e), .valid_e(valid_e),
    .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e)
  );

  function automatic logic [XLEN-1:0] operand(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] regval);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return alu_result_m;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return result_w;
    return regval;
  endfunction

  function automatic logic model_stall();
    return m.valid && m.mr && m.rd != 0 && valid_d && (m.rd == rs1_d || m.rd == rs2_d);
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [XLEN-1:0] fb;
    #1;
    fb = operand(m.rs2, m.rd2);
    chk("stall_d", XLEN'(stall_d), XLEN'(model_stall()));
    chk("srcA", srcA, operand(m.rs1, m.rd1));
    chk("srcB", srcB, m.src ? m.imm : fb);
    chk("write_data_e", write_data_e, fb);
    chk("alu_control_e", XLEN'(alu_control_e), XLEN'(m.ctl));
    chk("pc_e", pc_e, m.pc);
    chk("rd_e", XLEN'(rd_e), XLEN'(m.rd));
    chk("ctrl_e", XLEN'({valid_e, reg_write_e, mem_read_e, mem_write_e}),
        XLEN'({m.valid, m.rw, m.mr, m.mw}));
  endtask

  task automatic model_reset();
    m = '{valid: 0, src: 0, rw: 0, mr: 0, mw: 0, rd1: 0, rd2: 0, imm: 0, pc: 0,
          rs1: 0, rs2: 0, rd: 0, ctl: 0};
  endtask

  // Check the current cycle, clock it, advance model, then return at the next falling edge.
  task automatic tick();
    logic st;
    check_all();
    st = model_stall();
    @(posedge clk);
    if (flush_e || st) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
    end else begin
      m.valid = valid_d; m.rd1 = rd1_d; m.rd2 = rd2_d; m.imm = imm_d; m.pc = pc_d;
      m.rs1 = rs1_d; m.rs2 = rs2_d; m.rd = rd_d; m.ctl = alu_control_d; m.src = alu_src_d;
      m.rw = reg_write_d; m.mr = mem_read_d; m.mw = mem_write_d;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid_d = 0; rd1_d = 0; rd2_d = 0; imm_d = 0; pc_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
    alu_control_d = 3'b000; alu_src_d = 0; reg_write_d = 0; mem_read_d = 0; mem_write_d = 0;
    flush_e = 0; alu_result_m = 0; rd_m = 0; reg_write_m = 0; result_w = 0; rd_w = 0;
    reg_write_w = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1;

    // Plain capture
    valid_d = 1; rd1_d = 5; rd2_d = 7; alu_control_d = 3'b010; rs1_d = 1; rs2_d = 2;
    rd_d = 3; reg_write_d = 1; pc_d = 32'h100;
    tick();
    chk("cap_srcA", srcA, 32'd5);
    chk("cap_srcB", srcB, 32'd7);
    chk("cap_ctl", XLEN'(alu_control_e), 32'd2);

    // Immediate select; write_data stays on rs2
    alu_src_d = 1; imm_d = 32'hFFFF_FFF0; rd2_d = 3; alu_control_d = 3'b110;
    tick();
    chk("imm_srcB", srcB, 32'hFFFF_FFF0);
    chk("imm_wdata", write_data_e, 32'd3);

    // Forwarding priority
    alu_src_d = 0; rs1_d = 4; rs2_d = 4; rd1_d = 32'h55; rd2_d = 32'h66;
    tick();
    reg_write_m = 1; rd_m = 4; alu_result_m = 32'h11;
    reg_write_w = 1; rd_w = 4; result_w = 32'h22;
    check_all();
    chk("fwd_mem", srcA, 32'h11);
    rd_m = 0;
    check_all();
    chk("fwd_wb", srcA, 32'h22);
    rd_w = 0;
    check_all();
    chk("fwd_none", srcA, 32'h55);
    idle_inputs();

    // Load-use: load to x6, dependent reads x6 on rs2
    valid_d = 1; mem_read_d = 1; reg_write_d = 1; rd_d = 6; rs1_d = 1;
    tick();
    mem_read_d = 0; rd_d = 7; rs1_d = 0; rs2_d = 6; rd2_d = 32'hDEAD; alu_control_d = 3'b001;
    check_all();
    chk("lu_stall", XLEN'(stall_d), 32'd1);
    tick();
    chk("lu_bubble", XLEN'({valid_e, reg_write_e}), 32'd0);
    tick();
    reg_write_w = 1; rd_w = 6; result_w = 32'h99;
    check_all();
    chk("lu_fwd_wb", srcB, 32'h99);
    idle_inputs();

    // Flush, then flush coinciding with a load-use stall
    valid_d = 1; mem_write_d = 1; rs1_d = 2;
    flush_e = 1;
    tick();
    chk("flush_bubble", XLEN'({valid_e, mem_write_e}), 32'd0);
    flush_e = 0; mem_write_d = 0; mem_read_d = 1; reg_write_d = 1; rd_d = 5;
    tick();
    mem_read_d = 0; rs1_d = 5; flush_e = 1;
    check_all();
    chk("flush_stall", XLEN'(stall_d), 32'd1);
    tick();
    chk("flush_stall_bubble", XLEN'(valid_e), 32'd0);
    idle_inputs();

    // Async reset between edges
    valid_d = 1; reg_write_d = 1; pc_d = 32'h200; rd_d = 9; rd1_d = 32'hA; alu_control_d = 3'b111;
    tick();
    chk("pre_reset_valid", XLEN'(valid_e), 32'd1);
    rst_n = 0;
    model_reset();
    check_all();
    chk("async_pc", pc_e, 32'd0);
    #1 rst_n = 1;
    tick();

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      valid_d = $urandom_range(0, 3) != 0;
      rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom; pc_d = $urandom;
      rs1_d = RA_W'($urandom_range(0, 3)); rs2_d = RA_W'($urandom_range(0, 3));
      rd_d = RA_W'($urandom_range(0, 3));
      alu_control_d = 3'($urandom); alu_src_d = 1'($urandom);
      reg_write_d = 1'($urandom); mem_read_d = $urandom_range(0, 2) == 0;
      mem_write_d = $urandom_range(0, 3) == 0;
      flush_e = $urandom_range(0, 7) == 0;
      alu_result_m = $urandom; rd_m = RA_W'($urandom_range(0, 3)); reg_write_m = 1'($urandom);
      result_w = $urandom; rd_w = RA_W'($urandom_range(0, 3)); reg_write_w = 1'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
